// File: rtl/even_parity_generator.sv
// Even/odd parity generator for a 4-bit nibble {a,b,c,d}.
// The parity bit e is registered: one clock of latency.
// A synchronous reset clears e to 0 for either parity sense.
module even_parity_generator #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    logic e_d;
    logic e_q;

    // Parity of the current nibble; inverted when odd parity is selected.
    always_comb begin
        e_d = a ^ b ^ c ^ d ^ ODD_PARITY;
    end

    // Register the parity bit. Reset takes priority over the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= 1'b0;
        end else begin
            e_q <= e_d;
        end
    end

    assign e = e_q;

endmodule

// File: tb/tb_even_parity_generator.sv
// Self-checking bench for even_parity_generator.
// Runs an even-parity instance and an odd-parity instance in parallel
// from the same stimulus and checks both against a ones-count model.
module tb_even_parity_generator;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic e_even;
    logic e_odd;

    int checks = 0;
    int errors = 0;

    even_parity_generator #(.ODD_PARITY(1'b0)) u_even (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e_even)
    );

    even_parity_generator #(.ODD_PARITY(1'b1)) u_odd (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: e makes the total number of ones (nibble plus e) even,
    // or odd for the odd variant. Reset forces 0.
    function automatic logic model_e(input logic r, input logic [3:0] n, input bit odd);
        int ones;
        bit want_odd_total;
        if (r) return 1'b0;
        ones = $countones(n);
        want_odd_total = odd;
        // choose e so that (ones + e) has the desired evenness
        if ((ones % 2 == 1) != want_odd_total) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [3:0] last_n;
    logic       last_r;

    // Apply inputs away from the edge, clock once, then check both instances.
    task automatic step(input logic r, input logic [3:0] n, input string tag);
        @(negedge clk);
        rst = r;
        {a, b, c, d} = n;
        @(posedge clk);
        #1;
        last_n = n;
        last_r = r;
        check({tag, "/even"}, e_even, model_e(r, n, 1'b0));
        check({tag, "/odd"},  e_odd,  model_e(r, n, 1'b1));
    endtask

    initial begin
        logic [3:0] seq [4];
        logic       seq_e [4];
        logic [3:0] rn;
        logic       rr;

        rst = 1'b1;
        {a, b, c, d} = 4'b0000;

        // Reset held two edges with all ones on the data inputs.
        step(1'b1, 4'b1111, "reset0");
        step(1'b1, 4'b1111, "reset1");
        check("reset_const_even", e_even, 1'b0);
        check("reset_const_odd",  e_odd,  1'b0);

        // Exhaustive sweep of all nibbles.
        for (int unsigned i = 0; i < 16; i++) begin
            step(1'b0, 4'(i), $sformatf("sweep_%0d", i));
        end

        // Spot values from the truth table.
        step(1'b0, 4'b0000, "ex0000"); check("ex0000_const", e_even, 1'b0);
        step(1'b0, 4'b1000, "ex1000"); check("ex1000_const", e_even, 1'b1);
        step(1'b0, 4'b1001, "ex1001"); check("ex1001_const", e_even, 1'b0);
        step(1'b0, 4'b1011, "ex1011"); check("ex1011_const", e_even, 1'b1);
        step(1'b0, 4'b1111, "ex1111"); check("ex1111_const", e_even, 1'b0);

        // Back-to-back changes every cycle.
        seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        seq_e = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b0, seq[i], $sformatf("b2b_%0d", i));
            check($sformatf("b2b_const_%0d", i), e_even, seq_e[i]);
        end

        // Mid-stream reset then release with 0001 held.
        step(1'b0, 4'b0001, "mid_pre");
        check("mid_pre_const", e_even, 1'b1);
        step(1'b1, 4'b0001, "mid_rst");
        check("mid_rst_even", e_even, 1'b0);
        check("mid_rst_odd",  e_odd,  1'b0);
        step(1'b0, 4'b0001, "mid_post");
        check("mid_post_const", e_even, 1'b1);

        // Odd-parity variant spot values.
        step(1'b0, 4'b0000, "odd0000"); check("odd0000_const", e_odd, 1'b1);
        step(1'b0, 4'b0110, "odd0110"); check("odd0110_const", e_odd, 1'b1);
        step(1'b0, 4'b0111, "odd0111"); check("odd0111_const", e_odd, 1'b0);

        // Inputs changing between edges must not disturb e.
        step(1'b0, 4'b0001, "hold_base");
        #1;
        {a, b, c, d} = 4'b0011;
        @(negedge clk);
        check("hold_even", e_even, model_e(1'b0, 4'b0001, 1'b0));
        check("hold_odd",  e_odd,  model_e(1'b0, 4'b0001, 1'b1));

        // Randomized stream with occasional reset.
        for (int unsigned i = 0; i < 200; i++) begin
            rn = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 9) == 0);
            step(rr, rn, $sformatf("rand_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
